fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the multicycle control FSM. It owns the PC, the return-address latch and the instruction register (IR). It runs the request/response handshake with instruction memory and decodes the IR into the fields the control FSM consumes: Opcode, funct, RegSelect, RegSelect2, locationSelect and Imm12. PC and IR updates are driven by the control outputs PCWrite, PCSelect, IRWrite and Call.

Parameters:
RESET_VECTOR, 16'h0000, PC value loaded on reset and on PCSelect=1
ADDR_W, 16, PC and instruction address width
MAX_WAIT, 15, imem response timeout in cycles before fetch_err is asserted

Ports:
CLK  in  1  system clock, all state on posedge
Reset  in  1  synchronous, active-high reset
PCWrite  in  1  update PC this cycle
PCSelect  in  2  next-PC source: 0=PC+1, 1=RESET_VECTOR, 2=jr_addr, 3={PC[15:12],IR[11:0]}
IRWrite  in  1  start a fetch at the current PC
Call  in  1  latch return address
jr_addr  in  16  register-indirect target (ALU result)
imem_addr  out  16  fetch address
imem_req  out  1  fetch request, held until accepted
imem_ack  in  1  request accepted
imem_valid  in  1  response data valid
imem_data  in  16  instruction word
PC  out  16  current PC
ReturnAddr  out  16  latched return address
IR  out  16  instruction register
Opcode  out  4  IR[15:12]
RegSelect  out  3  IR[11:9]
RegSelect2  out  3  IR[8:6]
locationSelect  out  1  IR[5]
funct  out  4  IR[3:0]
Imm12  out  12  IR[11:0], unextended
fetch_busy  out  1  fetch in progress; control holds in state 0
fetch_err  out  1  sticky timeout flag

Behaviour:
- Synchronous Reset dominates all other inputs. Reset values: PC=RESET_VECTOR, IR=0, ReturnAddr=0, imem_req=0, imem_addr=0, fetch_busy=0, fetch_err=0, drop=0, state=IDLE.
- Decoded field outputs are purely combinational from IR. No decode latency.
- PC update: on PCWrite=1, PC <= mux(PCSelect). Unsigned 16-bit arithmetic; PC+1 wraps 16'hFFFF→16'h0000.
  - PCSelect=3 uses the IR value before any same-cycle IR load.
  - PCWrite=0 holds PC. A skip is simply a second PCWrite with PCSelect=0.
- Call=1: ReturnAddr <= PC, using the pre-update PC if PCWrite is also high.
- FSM states:
  - IDLE: on IRWrite, imem_addr <= PC (the old PC if PCWrite is coincident), imem_req <= 1, fetch_busy <= 1, counter <= 0 → REQ.
  - REQ: hold imem_req and imem_addr stable until imem_ack. On ack, drop imem_req → WAIT.
  - WAIT: on imem_valid, IR <= imem_data, fetch_busy <= 0 → IDLE.
- imem_ack and imem_valid may arrive in the same cycle. Treat this as ack+data: go REQ→IDLE and load IR.
- IRWrite while fetch_busy is ignored. Exactly one outstanding request at any time.
- Timeout: counter increments in REQ and WAIT. When it reaches MAX_WAIT, set fetch_err (sticky until Reset), deassert imem_req and fetch_busy, leave IR unchanged → IDLE.
- imem_valid in IDLE (stray) is ignored; IR is unchanged.
- Reset mid-fetch (REQ or WAIT): state → IDLE and drop <= 1 if a request was already acked. The next imem_valid clears drop and is discarded, not loaded into IR. A new IRWrite while drop=1 is accepted, but its response is the one after the discarded one.
- The PC and IR datapaths are independent. PCWrite/PCSelect are honoured in every state, including while fetch_busy.

Test Plan:
- Reset then IRWrite+PCWrite(sel 0) with memory returning 16'h2005 two cycles later → imem_addr=0, PC=1, fetch_busy high 3 cycles, IR=16'h2005, Opcode=2, Imm12=12'h005.
- IR=16'h0A4B (add), then check fields → RegSelect=5, RegSelect2=1, locationSelect=0, funct=4'hB. Same-cycle ack+valid → single-cycle REQ→IDLE.
- PC=16'h1234, IR=16'h4ABC (call): Call, then PCWrite sel 3 → ReturnAddr=16'h1234, PC=16'h1ABC. Then PCWrite sel 2 with jr_addr=16'h1234 → PC=16'h1234.
- PC=16'hFFFF, PCWrite sel 0 → PC=16'h0000. Skip case: two PCWrite sel 0 from PC=10 → PC=12.
- Memory never responds → fetch_err=1 after 15 cycles, fetch_busy=0, IR unchanged. Reset clears fetch_err.
- Reset asserted in WAIT, then late imem_valid=16'hDEAD → IR stays 0. Next fetch returns 16'h1111 → IR=16'h1111.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC/return-address/IR owner with a timed request-response instruction fetch and IR field decode
module fetch_unit #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int MAX_WAIT = 15
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              PCWrite,
  input  logic [1:0]        PCSelect,
  input  logic              IRWrite,
  input  logic              Call,
  input  logic [ADDR_W-1:0] jr_addr,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic              imem_valid,
  input  logic [15:0]       imem_data,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] ReturnAddr,
  output logic [15:0]       IR,
  output logic [3:0]        Opcode,
  output logic [2:0]        RegSelect,
  output logic [2:0]        RegSelect2,
  output logic              locationSelect,
  output logic [3:0]        funct,
  output logic [11:0]       Imm12,
  output logic              fetch_busy,
  output logic              fetch_err
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_next, ra_q, ra_d, addr_q, addr_d;
  logic [15:0] ir_q, ir_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic err_q, err_d, drop_q, drop_d, rst_drop, valid_eff, timeout;
  always_comb begin
    pc_next = PCSelect == 2'd0 ? pc_q + ADDR_W'(1) :
              PCSelect == 2'd1 ? RESET_VECTOR :
              PCSelect == 2'd2 ? jr_addr : {pc_q[ADDR_W-1:12], ir_q[11:0]};
    pc_d = PCWrite ? pc_next : pc_q;
    ra_d = Call ? pc_q : ra_q;
    valid_eff = imem_valid & ~drop_q;
    cnt_inc = cnt_q + CW'(1);
    timeout = cnt_inc == CW'(MAX_WAIT);
    state_d = state_q;
    addr_d = addr_q;
    ir_d = ir_q;
    cnt_d = cnt_q;
    err_d = err_q;
    drop_d = drop_q & ~imem_valid;
    case (state_q)
      S_IDLE: begin
        if (IRWrite) begin
          addr_d = pc_q;
          cnt_d = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = cnt_inc;
        if (imem_ack && valid_eff) begin
          ir_d = imem_data;
          state_d = S_IDLE;
        end else if (imem_ack) begin
          state_d = S_WAIT;
        end else if (timeout) begin
          err_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (valid_eff) begin
          ir_d = imem_data;
          state_d = S_IDLE;
        end else if (timeout) begin
          err_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // an accepted request whose response has not yet shown up must be discarded after reset
    rst_drop = (drop_q & ~imem_valid) | (~valid_eff & (state_q == S_WAIT || (state_q == S_REQ && imem_ack)));
  end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q <= RESET_VECTOR;
      ra_q <= '0;
      addr_q <= '0;
      ir_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      drop_q <= rst_drop;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ra_q <= ra_d;
      addr_q <= addr_d;
      ir_q <= ir_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      drop_q <= drop_d;
    end
  end
  assign imem_addr = addr_q;
  assign imem_req = state_q == S_REQ;
  assign fetch_busy = state_q != S_IDLE;
  assign fetch_err = err_q;
  assign PC = pc_q;
  assign ReturnAddr = ra_q;
  assign IR = ir_q;
  assign Opcode = ir_q[15:12];
  assign RegSelect = ir_q[11:9];
  assign RegSelect2 = ir_q[8:6];
  assign locationSelect = ir_q[5];
  assign funct = ir_q[3:0];
  assign Imm12 = ir_q[11:0];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven vectors plus hand sequences for timeout and reset-during-fetch
module tb_fetch_unit;
  logic CLK = 1'b0, Reset = 1'b0, PCWrite = 1'b0, IRWrite = 1'b0, Call = 1'b0;
  logic [1:0] PCSelect = 2'd0;
  logic [15:0] jr_addr = '0, imem_data = '0;
  logic imem_ack = 1'b0, imem_valid = 1'b0;
  logic [15:0] imem_addr, PC, ReturnAddr, IR;
  logic imem_req, locationSelect, fetch_busy, fetch_err;
  logic [3:0] Opcode, funct;
  logic [2:0] RegSelect, RegSelect2;
  logic [11:0] Imm12;
  int errors = 0, checks = 0;
  fetch_unit dut (
    .CLK(CLK), .Reset(Reset), .PCWrite(PCWrite), .PCSelect(PCSelect), .IRWrite(IRWrite),
    .Call(Call), .jr_addr(jr_addr), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ack(imem_ack), .imem_valid(imem_valid), .imem_data(imem_data), .PC(PC),
    .ReturnAddr(ReturnAddr), .IR(IR), .Opcode(Opcode), .RegSelect(RegSelect),
    .RegSelect2(RegSelect2), .locationSelect(locationSelect), .funct(funct), .Imm12(Imm12),
    .fetch_busy(fetch_busy), .fetch_err(fetch_err)
  );
  always #5 CLK = ~CLK;
  typedef struct {
    logic rst, pcw;
    logic [1:0] sel;
    logic irw, call;
    logic [15:0] jr;
    logic ack, vld;
    logic [15:0] data, pc, ir, ra, addr;
    logic busy, req, err;
  } vec_t;
  vec_t v[25];
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic rst, pcw, input logic [1:0] sel, input logic irw, call,
                       input logic [15:0] jr, input logic ack, vld, input logic [15:0] data);
    Reset = rst; PCWrite = pcw; PCSelect = sel; IRWrite = irw; Call = call;
    jr_addr = jr; imem_ack = ack; imem_valid = vld; imem_data = data;
  endtask
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask
  task automatic step(input logic rst, irw, ack, vld, input logic [15:0] data);
    drive(rst, 1'b0, 2'd0, irw, 1'b0, 16'h0, ack, vld, data);
    cyc();
  endtask
  initial begin
    v[0]  = '{1,0,0,0,0,16'h0000,0,0,16'h0000, 16'h0000,16'h0000,16'h0000,16'h0000,0,0,0};
    v[1]  = '{0,1,0,1,0,16'h0000,0,0,16'h0000, 16'h0001,16'h0000,16'h0000,16'h0000,1,1,0};
    v[2]  = '{0,0,0,0,0,16'h0000,0,0,16'h0000, 16'h0001,16'h0000,16'h0000,16'h0000,1,1,0};
    v[3]  = '{0,0,0,0,0,16'h0000,1,0,16'h0000, 16'h0001,16'h0000,16'h0000,16'h0000,1,0,0};
    v[4]  = '{0,0,0,0,0,16'h0000,0,1,16'h2005, 16'h0001,16'h2005,16'h0000,16'h0000,0,0,0};
    v[5]  = '{0,0,0,1,0,16'h0000,0,0,16'h0000, 16'h0001,16'h2005,16'h0000,16'h0001,1,1,0};
    v[6]  = '{0,0,0,0,0,16'h0000,1,1,16'h0A4B, 16'h0001,16'h0A4B,16'h0000,16'h0001,0,0,0};
    v[7]  = '{0,1,2,0,0,16'h1234,0,0,16'h0000, 16'h1234,16'h0A4B,16'h0000,16'h0001,0,0,0};
    v[8]  = '{0,0,0,1,0,16'h0000,0,0,16'h0000, 16'h1234,16'h0A4B,16'h0000,16'h1234,1,1,0};
    v[9]  = '{0,0,0,0,0,16'h0000,1,0,16'h0000, 16'h1234,16'h0A4B,16'h0000,16'h1234,1,0,0};
    v[10] = '{0,0,0,0,0,16'h0000,0,1,16'h4ABC, 16'h1234,16'h4ABC,16'h0000,16'h1234,0,0,0};
    v[11] = '{0,1,3,0,1,16'h0000,0,0,16'h0000, 16'h1ABC,16'h4ABC,16'h1234,16'h1234,0,0,0};
    v[12] = '{0,1,2,0,0,16'h1234,0,0,16'h0000, 16'h1234,16'h4ABC,16'h1234,16'h1234,0,0,0};
    v[13] = '{0,1,2,0,0,16'hFFFF,0,0,16'h0000, 16'hFFFF,16'h4ABC,16'h1234,16'h1234,0,0,0};
    v[14] = '{0,1,0,0,0,16'h0000,0,0,16'h0000, 16'h0000,16'h4ABC,16'h1234,16'h1234,0,0,0};
    v[15] = '{0,1,2,0,0,16'h000A,0,0,16'h0000, 16'h000A,16'h4ABC,16'h1234,16'h1234,0,0,0};
    v[16] = '{0,1,0,0,0,16'h0000,0,0,16'h0000, 16'h000B,16'h4ABC,16'h1234,16'h1234,0,0,0};
    v[17] = '{0,1,0,0,0,16'h0000,0,0,16'h0000, 16'h000C,16'h4ABC,16'h1234,16'h1234,0,0,0};
    v[18] = '{0,1,1,0,0,16'h0000,0,0,16'h0000, 16'h0000,16'h4ABC,16'h1234,16'h1234,0,0,0};
    v[19] = '{0,0,0,0,0,16'h0000,0,1,16'h9999, 16'h0000,16'h4ABC,16'h1234,16'h1234,0,0,0};
    v[20] = '{0,1,2,1,0,16'h0050,0,0,16'h0000, 16'h0050,16'h4ABC,16'h1234,16'h0000,1,1,0};
    v[21] = '{0,0,0,1,0,16'h0000,0,0,16'h0000, 16'h0050,16'h4ABC,16'h1234,16'h0000,1,1,0};
    v[22] = '{0,0,0,0,0,16'h0000,1,0,16'h0000, 16'h0050,16'h4ABC,16'h1234,16'h0000,1,0,0};
    v[23] = '{0,1,0,0,0,16'h0000,0,0,16'h0000, 16'h0051,16'h4ABC,16'h1234,16'h0000,1,0,0};
    v[24] = '{0,0,0,0,0,16'h0000,0,1,16'h7777, 16'h0051,16'h7777,16'h1234,16'h0000,0,0,0};
    #1;
    for (int i = 0; i < 25; i++) begin
      drive(v[i].rst, v[i].pcw, v[i].sel, v[i].irw, v[i].call, v[i].jr, v[i].ack, v[i].vld, v[i].data);
      cyc();
      chk($sformatf("v%0d PC", i), PC, v[i].pc);
      chk($sformatf("v%0d IR", i), IR, v[i].ir);
      chk($sformatf("v%0d ReturnAddr", i), ReturnAddr, v[i].ra);
      chk($sformatf("v%0d imem_addr", i), imem_addr, v[i].addr);
      chk($sformatf("v%0d fetch_busy", i), {15'd0, fetch_busy}, {15'd0, v[i].busy});
      chk($sformatf("v%0d imem_req", i), {15'd0, imem_req}, {15'd0, v[i].req});
      chk($sformatf("v%0d fetch_err", i), {15'd0, fetch_err}, {15'd0, v[i].err});
      if (i == 4) begin
        chk("Opcode 2005", {12'd0, Opcode}, 16'h0002);
        chk("Imm12 2005", {4'd0, Imm12}, 16'h0005);
      end
      if (i == 6) begin
        chk("Opcode 0A4B", {12'd0, Opcode}, 16'h0000);
        chk("RegSelect 0A4B", {13'd0, RegSelect}, 16'h0005);
        chk("RegSelect2 0A4B", {13'd0, RegSelect2}, 16'h0001);
        chk("locationSelect 0A4B", {15'd0, locationSelect}, 16'h0000);
        chk("funct 0A4B", {12'd0, funct}, 16'h000B);
      end
    end
    step(0, 1, 0, 0, 16'h0);
    chk("to addr", imem_addr, 16'h0051);
    for (int k = 1; k < 15; k++) step(0, 0, 0, 0, 16'h0);
    chk("to err early", {15'd0, fetch_err}, 16'h0000);
    chk("to busy early", {15'd0, fetch_busy}, 16'h0001);
    step(0, 0, 0, 0, 16'h0);
    chk("to err", {15'd0, fetch_err}, 16'h0001);
    chk("to busy", {15'd0, fetch_busy}, 16'h0000);
    chk("to req", {15'd0, imem_req}, 16'h0000);
    chk("to IR", IR, 16'h7777);
    step(0, 0, 0, 0, 16'h0);
    step(0, 0, 0, 0, 16'h0);
    chk("err sticky", {15'd0, fetch_err}, 16'h0001);
    step(1, 0, 0, 0, 16'h0);
    chk("err cleared", {15'd0, fetch_err}, 16'h0000);
    chk("rst PC", PC, 16'h0000);
    step(0, 1, 0, 0, 16'h0);
    step(0, 0, 1, 0, 16'h0);
    chk("b1 wait busy", {15'd0, fetch_busy}, 16'h0001);
    step(1, 0, 0, 0, 16'h0);
    chk("b1 rst busy", {15'd0, fetch_busy}, 16'h0000);
    step(0, 0, 0, 1, 16'hDEAD);
    chk("b1 late IR", IR, 16'h0000);
    chk("b1 late busy", {15'd0, fetch_busy}, 16'h0000);
    step(0, 1, 0, 0, 16'h0);
    chk("b1 req", {15'd0, imem_req}, 16'h0001);
    step(0, 0, 1, 1, 16'h1111);
    chk("b1 IR", IR, 16'h1111);
    chk("b1 busy", {15'd0, fetch_busy}, 16'h0000);
    step(0, 1, 0, 0, 16'h0);
    step(0, 0, 1, 0, 16'h0);
    step(1, 0, 0, 0, 16'h0);
    step(0, 1, 0, 0, 16'h0);
    chk("b2 accepted", {15'd0, fetch_busy}, 16'h0001);
    step(0, 0, 1, 0, 16'h0);
    step(0, 0, 0, 1, 16'hDEAD);
    chk("b2 discard IR", IR, 16'h0000);
    chk("b2 still busy", {15'd0, fetch_busy}, 16'h0001);
    step(0, 0, 0, 1, 16'h2222);
    chk("b2 IR", IR, 16'h2222);
    chk("b2 busy", {15'd0, fetch_busy}, 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
